// File: rtl/gsensor_spi_pkg.sv
// gsensor_spi_pkg
// Shared types and constants for the ADXL345 G-sensor SPI master.
//   - spi_state_e : transaction FSM states
//   - FRAME_LEN   : bits per frame (command byte + data byte)
//   - CMD_*       : bit positions of the command fields inside the frame
//   - REG_*       : ADXL345 register addresses used by the sequencer
package gsensor_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    localparam int FRAME_LEN = 16;

    localparam int CMD_RW_BIT   = 15;
    localparam int CMD_MB_BIT   = 14;
    localparam int CMD_ADDR_MSB = 13;
    localparam int CMD_ADDR_LSB = 8;

    localparam logic [5:0] REG_DEVID       = 6'h00;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

endpackage

// File: rtl/gsensor_clk_edge_sync.sv
// gsensor_clk_edge_sync
// Brings the divided SPI clock into the iClk50M domain and turns its edges
// into single-cycle ticks. The divided clock is only ever treated as data.
//   iClk50M    in   system clock
//   iRst_n     in   async active-low reset (all flops reset to 1 = SCLK idle level)
//   iSpiClk    in   divided clock from the clock divider
//   oTickRise  out  one-cycle pulse after a rising edge of iSpiClk
//   oTickFall  out  one-cycle pulse after a falling edge of iSpiClk
module gsensor_clk_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk50M,
    input  logic iRst_n,
    input  logic iSpiClk,
    output logic oTickRise,
    output logic oTickFall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Resetting to 1 matches the idle-high divider output, so leaving reset
    // with iSpiClk high produces no spurious tick.
    always_ff @(posedge iClk50M or negedge iRst_n) begin
        if (!iRst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iSpiClk};
            hist_q <= sync_out;
        end
    end

    assign oTickRise = sync_out & ~hist_q;
    assign oTickFall = ~sync_out & hist_q;

endmodule

// File: rtl/gsensor_spi_master.sv
// gsensor_spi_master
// Single-frame SPI mode-3 master for the ADXL345: one command byte
// {RW, MB, ADDR} followed by one data byte per iStart.
//   iClk50M   in   system clock
//   iRst_n    in   async active-low reset
//   iSpiClk   in   divided bit-rate clock (used as a tick source only)
//   iStart    in   transaction request, honoured only in IDLE
//   iRw       in   1 = read (data byte sent as 0x00), 0 = write
//   iMb       in   multi-byte bit, copied into the command byte
//   iAddr     in   register address
//   iWrData   in   write byte
//   iMiso     in   sensor SDO
//   oSclk     out  SPI clock, idles high
//   oCs_n     out  chip select, active low
//   oMosi     out  sensor SDI, idles high
//   oBusy     out  high whenever the FSM is not IDLE
//   oDone     out  one-cycle pulse at end of frame
//   oRdData   out  byte clocked in during the data byte, held until next oDone
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | CS high, waiting for iStart
// SETUP | CS low, waiting for a divider rise so CS leads the first SCLK fall
// SHIFT | 16 bits: MOSI/SCLK low on divider fall, MISO/SCLK high on rise
// HOLD  | last SCLK rise done, release CS on the next divider fall
// GAP   | CS high for half a period, then publish data and pulse oDone
module gsensor_spi_master
    import gsensor_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8
) (
    input  logic              iClk50M,
    input  logic              iRst_n,
    input  logic              iSpiClk,
    input  logic              iStart,
    input  logic              iRw,
    input  logic              iMb,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iMiso,
    output logic              oSclk,
    output logic              oCs_n,
    output logic              oMosi,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oRdData
);

    localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_LEN - 1);

    logic                 tick_rise;
    logic                 tick_fall;
    logic [FRAME_LEN-1:0] frame_load;

    spi_state_e           state_q;
    logic [FRAME_LEN-1:0] shift_q;
    logic [DATA_W-1:0]    rx_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 sclk_q;
    logic                 cs_n_q;
    logic                 mosi_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DATA_W-1:0]    rd_data_q;

    gsensor_clk_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .iClk50M   (iClk50M),
        .iRst_n    (iRst_n),
        .iSpiClk   (iSpiClk),
        .oTickRise (tick_rise),
        .oTickFall (tick_fall)
    );

    // A read sends 0x00 in the data byte regardless of iWrData.
    always_comb begin
        frame_load                             = '0;
        frame_load[CMD_RW_BIT]                 = iRw;
        frame_load[CMD_MB_BIT]                 = iMb;
        frame_load[CMD_ADDR_MSB:CMD_ADDR_LSB]  = iAddr;
        frame_load[DATA_W-1:0]                 = iRw ? '0 : iWrData;
    end

    always_ff @(posedge iClk50M or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (iStart) begin
                        shift_q   <= frame_load;
                        bit_cnt_q <= '0;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick_rise) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_fall) begin
                        sclk_q  <= 1'b0;
                        mosi_q  <= shift_q[FRAME_LEN-1];
                        shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
                    end
                    if (tick_rise) begin
                        sclk_q    <= 1'b1;
                        rx_q      <= {rx_q[DATA_W-2:0], iMiso};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick_fall) begin
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    // rx holds the last DATA_W bits, i.e. the data byte, on
                    // writes as well as reads.
                    if (tick_rise) begin
                        rd_data_q <= rx_q;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oSclk   = sclk_q;
    assign oCs_n   = cs_n_q;
    assign oMosi   = mosi_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oRdData = rd_data_q;

endmodule

// File: tb/tb_gsensor_spi_master.sv
module tb_gsensor_spi_master;

    logic       clk;
    logic       rst_n;
    logic       spi_clk;
    logic       start;
    logic       rw;
    logic       mb;
    logic [5:0] addr;
    logic [7:0] wr_data;
    logic       miso = 1'b1;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;

    gsensor_spi_master dut (
        .iClk50M (clk),
        .iRst_n  (rst_n),
        .iSpiClk (spi_clk),
        .iStart  (start),
        .iRw     (rw),
        .iMb     (mb),
        .iAddr   (addr),
        .iWrData (wr_data),
        .iMiso   (miso),
        .oSclk   (sclk),
        .oCs_n   (cs_n),
        .oMosi   (mosi),
        .oBusy   (busy),
        .oDone   (done),
        .oRdData (rd_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Divider model: 20-cycle period. When spi_run is cleared it parks high.
    logic spi_run = 1'b1;
    int   spi_div = 0;
    initial begin
        spi_clk = 1'b1;
        forever begin
            @(negedge clk);
            if (spi_run || !spi_clk) begin
                spi_div++;
                if (spi_div == 10) begin
                    spi_div = 0;
                    spi_clk = ~spi_clk;
                end
            end
        end
    end

    // SPI bus monitor and sensor model.
    logic        prev_sclk = 1'b1;
    logic        prev_cs_n = 1'b1;
    logic        prev_mosi = 1'b1;
    int          rise_cnt = 0, fall_cnt = 0, viol_cnt = 0, cs_high_cnt = 0;
    int          last_rises = 0, last_falls = 0, last_viol = 0, last_gap = 0;
    logic [15:0] mosi_cap = '0, last_mosi = '0, cur_miso = '0;
    logic [15:0] miso_word = '0;

    always @(negedge clk) begin
        if (prev_cs_n && !cs_n) begin
            last_gap    = cs_high_cnt;
            cs_high_cnt = 0;
            rise_cnt    = 0;
            fall_cnt    = 0;
            viol_cnt    = 0;
            mosi_cap    = '0;
            cur_miso    = miso_word;
        end
        if (!prev_cs_n && !cs_n) begin
            if (prev_sclk && !sclk) begin
                if (fall_cnt < 16) miso = cur_miso[15 - fall_cnt];
                fall_cnt++;
            end
            if (!prev_sclk && sclk) begin
                mosi_cap = {mosi_cap[14:0], mosi};
                rise_cnt++;
            end
            if (mosi !== prev_mosi && !(prev_sclk && !sclk)) viol_cnt++;
        end
        if (!prev_cs_n && cs_n) begin
            last_mosi  = mosi_cap;
            last_rises = rise_cnt;
            last_falls = fall_cnt;
            last_viol  = viol_cnt;
        end
        if (cs_n) cs_high_cnt++;
        prev_sclk = sclk;
        prev_cs_n = cs_n;
        prev_mosi = mosi;
    end

    // Scoreboard: expectations pushed by stimulus, popped on every oDone.
    typedef struct {
        logic [15:0] mosi;
        logic [7:0]  rd;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: oDone with no frame pending, rd=0x%0h", rd_data);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_mosi"},  last_mosi,  mon_e.mosi);
                chk({mon_e.tag, "_rd"},    rd_data,    mon_e.rd);
                chk({mon_e.tag, "_rises"}, last_rises, 16);
                chk({mon_e.tag, "_falls"}, last_falls, 16);
                chk({mon_e.tag, "_mosi_glitch"}, last_viol, 0);
                chk({mon_e.tag, "_busy_at_done"}, busy, 0);
                chk({mon_e.tag, "_sclk_at_done"}, sclk, 1);
                chk({mon_e.tag, "_cs_at_done"},   cs_n, 1);
            end
        end
    end

    // Called at a negedge; returns two negedges later so the bus monitor has
    // already seen CS fall.
    task automatic drive_start(input logic r, input logic m, input logic [5:0] a, input logic [7:0] w);
        rw      = r;
        mb      = m;
        addr    = a;
        wr_data = w;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle_timeout: busy=%0b, required 0", name, busy);
        end
    endtask

    task automatic wait_done_cnt(input string name, input int target);
        for (int i = 0; i < 4000 && done_cnt < target; i++) @(negedge clk);
        if (done_cnt < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_timeout: done_cnt=%0d, required %0d", name, done_cnt, target);
        end
    endtask

    task automatic run_frame(input logic r, input logic m, input logic [5:0] a, input logic [7:0] w,
                             input logic [15:0] sensor, input logic [15:0] exp_mosi,
                             input logic [7:0] exp_rd, input string tag);
        int snap;
        exp_t e;
        wait_idle(tag);
        snap      = done_cnt;
        miso_word = sensor;
        e.mosi    = exp_mosi;
        e.rd      = exp_rd;
        e.tag     = tag;
        sb.push_back(e);
        drive_start(r, m, a, w);
        wait_done_cnt(tag, snap + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int   snap;
        exp_t e;

        rst_n   = 1'b0;
        start   = 1'b0;
        rw      = 1'b0;
        mb      = 1'b0;
        addr    = '0;
        wr_data = '0;
        repeat (5) @(negedge clk);
        chk("rst_sclk", sclk, 1);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_mosi", mosi, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd",   rd_data, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write POWER_CTL = 0x08.
        run_frame(1'b0, 1'b0, 6'h2D, 8'h08, 16'h00A5, 16'h2D08, 8'hA5, "wr_2d08");

        // Read DEVID, sensor answers 0xE5.
        run_frame(1'b1, 1'b0, 6'h00, 8'h5A, 16'h00E5, 16'h8000, 8'hE5, "rd_devid");

        // Busy lockout: second iStart at bit 6 must be dropped.
        wait_idle("lockout");
        snap      = done_cnt;
        miso_word = 16'h0033;
        e.mosi    = 16'hF200;
        e.rd      = 8'h33;
        e.tag     = "rd_mb_32";
        sb.push_back(e);
        drive_start(1'b1, 1'b1, 6'h32, 8'h00);
        for (int i = 0; i < 2000 && rise_cnt < 6; i++) @(negedge clk);
        drive_start(1'b0, 1'b0, 6'h2D, 8'hFF);
        wait_done_cnt("lockout", snap + 1);
        repeat (200) @(negedge clk);
        chk("lockout_busy_after", busy, 0);
        chk("lockout_cs_after",   cs_n, 1);
        chk("lockout_done_count", done_cnt, snap + 1);

        // Reset mid-frame after 5 bits.
        wait_idle("midrst");
        snap      = done_cnt;
        miso_word = 16'hFFFF;
        drive_start(1'b0, 1'b0, 6'h2D, 8'h00);
        for (int i = 0; i < 2000 && rise_cnt < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_sclk", sclk, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_mosi", mosi, 1);
        chk("midrst_rd",   rd_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("midrst_no_done", done_cnt, snap);
        run_frame(1'b0, 1'b0, 6'h31, 8'h0B, 16'h005A, 16'h310B, 8'h5A, "wr_310b");

        // Stalled divider: park iSpiClk high, FSM must sit in SETUP.
        wait_idle("stall");
        spi_run = 1'b0;
        for (int i = 0; i < 100 && !spi_clk; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        snap      = done_cnt;
        miso_word = 16'h000B;
        e.mosi    = 16'hB100;
        e.rd      = 8'h0B;
        e.tag     = "rd_stall";
        sb.push_back(e);
        drive_start(1'b1, 1'b0, 6'h31, 8'h00);
        repeat (200) @(negedge clk);
        chk("stall_busy",  busy, 1);
        chk("stall_cs_n",  cs_n, 0);
        chk("stall_sclk",  sclk, 1);
        chk("stall_rises", rise_cnt, 0);
        chk("stall_falls", fall_cnt, 0);
        spi_run = 1'b1;
        wait_done_cnt("stall", snap + 1);

        // Back-to-back: iStart during the oDone cycle.
        wait_idle("b2b");
        snap      = done_cnt;
        miso_word = 16'h0011;
        e.mosi    = 16'h2D08;
        e.rd      = 8'h11;
        e.tag     = "b2b_a";
        sb.push_back(e);
        drive_start(1'b0, 1'b0, 6'h2D, 8'h08);
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        miso_word = 16'h00E5;
        e.mosi    = 16'h8000;
        e.rd      = 8'hE5;
        e.tag     = "b2b_b";
        sb.push_back(e);
        drive_start(1'b1, 1'b0, 6'h00, 8'h00);
        chk("b2b_second_started", cs_n, 0);
        n_cmp++;
        if (last_gap < 10) begin
            n_bad++;
            $display("FAIL b2b_cs_gap: got %0d cycles, required >= 10", last_gap);
        end
        wait_done_cnt("b2b", snap + 2);

        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
